// File: rtl/mp_add_pkg.sv
// Shared definitions for the limb-serial multi-precision adder: FSM states and limb-index sizing.
package mp_add_pkg;

    localparam int MP_LIMB_W  = 64;
    localparam int MP_N_LIMBS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Limb-index width; N_LIMBS is always >= 2 so $clog2 never yields zero.
    function automatic int idx_w(input int n_limbs);
        return $clog2(n_limbs);
    endfunction

endpackage

// File: rtl/mp_limb_adder.sv
// Single shared LIMB_W-bit combinational adder with carry in/out.
module mp_limb_adder #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] iA,
    input  logic [LIMB_W-1:0] iB,
    input  logic              iC,
    output logic [LIMB_W-1:0] oSum,
    output logic              oC
);

    logic [LIMB_W:0] w_full;

    assign w_full = {1'b0, iA} + {1'b0, iB} + {{LIMB_W{1'b0}}, iC};
    assign oSum   = w_full[LIMB_W-1:0];
    assign oC     = w_full[LIMB_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Limb-serial multi-precision adder: one limb per cycle, LSB first, carry held in a register.
// Defining MP_ADD_SUB_EN adds the iSub port and A-B support (B inverted, carry seed forced to 1).
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int LIMB_W  = MP_LIMB_W,
    parameter int N_LIMBS = MP_N_LIMBS
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStart,
    input  logic [LIMB_W*N_LIMBS-1:0] iA,
    input  logic [LIMB_W*N_LIMBS-1:0] iB,
    input  logic                      iCarryIn,
`ifdef MP_ADD_SUB_EN
    input  logic                      iSub,
`endif
    output logic                      oBusy,
    output logic                      oDone,
    output logic [LIMB_W*N_LIMBS-1:0] oResult,
    output logic                      oCarryOut,
    output logic [1:0]                oDbgState
);

    localparam int W     = LIMB_W * N_LIMBS;
    localparam int IDX_W = idx_w(N_LIMBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMBS - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic               r_cout;
    logic               r_done;

    logic [LIMB_W-1:0]  w_a_limb;
    logic [LIMB_W-1:0]  w_b_limb;
    logic [LIMB_W-1:0]  w_sum;
    logic               w_c;

    assign w_a_limb = r_a[r_idx*LIMB_W +: LIMB_W];
    assign w_b_limb = r_b[r_idx*LIMB_W +: LIMB_W];

    mp_limb_adder #(.LIMB_W(LIMB_W)) u_limb_adder (
        .iA   (w_a_limb),
        .iB   (w_b_limb),
        .iC   (r_carry),
        .oSum (w_sum),
        .oC   (w_c)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_a      <= iA;
`ifdef MP_ADD_SUB_EN
                        // Two's-complement subtract: A + ~B + 1.
                        r_b      <= iSub ? ~iB : iB;
                        r_carry  <= iSub ? 1'b1 : iCarryIn;
`else
                        r_b      <= iB;
                        r_carry  <= iCarryIn;
`endif
                        r_idx    <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[r_idx*LIMB_W +: LIMB_W] <= w_sum;
                    r_carry <= w_c;
                    // Index holds on the last limb; it only returns to 0 through accept.
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oBusy     = (r_state != ST_IDLE);
    assign oDone     = r_done;
    assign oResult   = r_result;
    assign oCarryOut = r_cout;
    assign oDbgState = r_state;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: directed corners plus random operands against an arithmetic model.
module tb_mp_add_sequencer;

  localparam int LIMB_W  = 64;
  localparam int N_LIMBS = 4;
  localparam int W       = LIMB_W * N_LIMBS;

  logic          iClk;
  logic          iRst;
  logic          iStart;
  logic [W-1:0]  iA;
  logic [W-1:0]  iB;
  logic          iCarryIn;
`ifdef MP_ADD_SUB_EN
  logic          iSub;
`endif
  logic          oBusy;
  logic          oDone;
  logic [W-1:0]  oResult;
  logic          oCarryOut;
  logic [1:0]    oDbgState;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];

  mp_add_sequencer #(.LIMB_W(LIMB_W), .N_LIMBS(N_LIMBS)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iA        (iA),
    .iB        (iB),
    .iCarryIn  (iCarryIn),
`ifdef MP_ADD_SUB_EN
    .iSub      (iSub),
`endif
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult),
    .oCarryOut (oCarryOut),
    .oDbgState (oDbgState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    // Occasionally force whole limbs to all-ones to stress carry propagation.
    for (int l = 0; l < N_LIMBS; l++)
      if ($urandom_range(0, 3) == 0) r[l*LIMB_W +: LIMB_W] = '1;
    return r;
  endfunction

  task automatic do_reset();
    iRst = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic set_sub(input logic sub);
`ifdef MP_ADD_SUB_EN
    iSub = sub;
`else
    if (sub) $display("note: subtract requested without MP_ADD_SUB_EN");
`endif
  endtask

  // Drives one operation; glitch=1 pulses iStart with other operands during RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit glitch);
    logic [W:0] full;
    logic [W-1:0] e_res;
    logic e_c;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    exp_q.push_back(full[W-1:0]);
    exp_c_q.push_back(full[W]);

    @(negedge iClk);
    iA = a; iB = b; iCarryIn = cin; set_sub(sub); iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iA = rand_w(); iB = rand_w(); iCarryIn = 1'($urandom_range(0, 1)); set_sub(1'($urandom_range(0, 1)));
    check_val("busy_e0", W'(oBusy), W'(1));
    check_val("done_e0", W'(oDone), W'(0));
    check_val("res_clr_e0", oResult, '0);

    for (int k = 1; k <= N_LIMBS; k++) begin
      if (glitch && k == 2) iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      check_val($sformatf("done_e%0d", k), W'(oDone), W'(k == N_LIMBS));
    end

    e_res = exp_q.pop_front();
    e_c   = exp_c_q.pop_front();
    check_val("result", oResult, e_res);
    check_val("carry_out", W'(oCarryOut), W'(e_c));
    check_val("busy_done", W'(oBusy), W'(1));

    @(posedge iClk); #1;
    check_val("done_e5", W'(oDone), W'(0));
    check_val("busy_e5", W'(oBusy), W'(0));
    check_val("result_held", oResult, e_res);
    @(posedge iClk); #1;
    check_val("busy_e6", W'(oBusy), W'(0));
  endtask

  initial begin
    logic [W-1:0] r_exp;
    int done_cnt;
    iRst = 1'b1; iStart = 1'b0; iA = '0; iB = '0; iCarryIn = 1'b0;
    set_sub(1'b0);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      @(posedge iClk); #1;
      check_val("rst_busy", W'(oBusy), W'(0));
      check_val("rst_done", W'(oDone), W'(0));
      check_val("rst_result", oResult, '0);
      check_val("rst_cout", W'(oCarryOut), W'(0));
    end

    // full-width carry ripple through every limb register
    run_op('1, '0, 1'b1, 1'b0, 1'b0);
    // carry crosses limb 0 -> limb 1
    run_op({128'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0, 1'b0, 1'b0);
    // start during RUN ignored
    run_op(rand_w(), rand_w(), 1'b0, 1'b0, 1'b1);

    // reset mid-operation aborts with no oDone
    @(negedge iClk);
    iA = rand_w(); iB = rand_w(); iCarryIn = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1; iStart = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check_val("abort_busy", W'(oBusy), W'(0));
    check_val("abort_result", oResult, '0);
    check_val("abort_cout", W'(oCarryOut), W'(0));
    done_cnt = 0;
    for (int i = 0; i < N_LIMBS + 2; i++) begin
      @(posedge iClk); #1;
      if (oDone) done_cnt++;
    end
    check_val("abort_no_done", W'(done_cnt), W'(0));

    // reset and start together: reset wins
    @(negedge iClk);
    iRst = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0; iStart = 1'b0;
    @(posedge iClk); #1;
    check_val("rst_start_busy", W'(oBusy), W'(0));

    run_op(rand_w(), rand_w(), 1'b1, 1'b0, 1'b0);

    // held start: accepts at E0 and again at E6, oDone at E4 and E10
    @(negedge iClk);
    iA = rand_w(); iB = rand_w(); iCarryIn = 1'b0; set_sub(1'b0); iStart = 1'b1;
    r_exp = iA + iB;
    for (int c = 0; c <= 11; c++) begin
      @(posedge iClk); #1;
      check_val($sformatf("held_done_c%0d", c), W'(oDone), W'(c == 4 || c == 10));
      if (c == 4 || c == 10) check_val("held_result", oResult, r_exp);
    end
    @(negedge iClk);
    iStart = 1'b0;
    repeat (N_LIMBS + 2) @(posedge iClk);
    #1;
    check_val("held_idle", W'(oBusy), W'(0));

`ifdef MP_ADD_SUB_EN
    run_op(W'(5), W'(7), 1'b0, 1'b1, 1'b0);
    run_op(W'(7), W'(5), 1'b0, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 20; n++) begin
`ifdef MP_ADD_SUB_EN
      run_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`else
      run_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
